// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared LSU codes, FSM states and size decode for mem_access
package mem_access_pkg;

    localparam int          REG_W      = 32;
    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Access size from funct3; unknown codes fall back to a full word.
    function automatic size_t f3_size(input logic [2:0] f3);
        size_t s;
        case (f3)
            F3_LB, F3_LBU: s = SZ_B;
            F3_LH, F3_LHU: s = SZ_H;
            default:       s = SZ_W;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable/store-lane generation, load extraction and misalign detect
module lsu_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  i_req_funct3,
    input  logic [1:0]  i_req_addr_lo,
    input  logic [31:0] i_req_wdata,
    output logic [3:0]  o_req_be,
    output logic [31:0] o_req_wdata,
    output logic        o_misalign,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    size_t       w_req_size;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    assign w_req_size = f3_size(i_req_funct3);

    // Request side: byte enables, lane-replicated store data, alignment check
    always_comb begin
        o_req_be    = 4'b1111;
        o_req_wdata = i_req_wdata;
        o_misalign  = 1'b0;
        case (w_req_size)
            SZ_B: begin
                o_req_be    = 4'b0001 << i_req_addr_lo;
                o_req_wdata = {4{i_req_wdata[7:0]}};
            end
            SZ_H: begin
                o_req_be    = i_req_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_req_wdata = {2{i_req_wdata[15:0]}};
                o_misalign  = i_req_addr_lo[0];
            end
            default: begin
                o_misalign  = |i_req_addr_lo;
            end
        endcase
    end

    // Load side: pick the addressed lane and sign/zero-extend it
    always_comb begin
        w_ld_byte = i_ld_rdata[7:0];
        case (i_ld_addr_lo)
            2'd0:    w_ld_byte = i_ld_rdata[7:0];
            2'd1:    w_ld_byte = i_ld_rdata[15:8];
            2'd2:    w_ld_byte = i_ld_rdata[23:16];
            default: w_ld_byte = i_ld_rdata[31:24];
        endcase
        w_ld_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
        case (i_ld_funct3)
            F3_LB:   o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            F3_LBU:  o_ld_data = {24'h0, w_ld_byte};
            F3_LH:   o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            F3_LHU:  o_ld_data = {16'h0, w_ld_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage: dmem req/gnt/rvalid port, pipeline hold, wb register
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [31:0]           inst_i,
    input  logic                  mem_r_ena_i,
    input  logic [ADDR_W-1:0]     mem_r_addr_i,
    input  logic                  mem_w_ena_i,
    input  logic [ADDR_W-1:0]     mem_w_addr_i,
    input  logic [DATA_W-1:0]     mem_w_data_i,
    input  logic                  reg_w_ena_i,
    input  logic [REG_ADDR_W-1:0] reg_w_addr_i,
    input  logic [DATA_W-1:0]     reg_w_data_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_W-1:0]     dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  reg_w_ena_o,
    output logic [REG_ADDR_W-1:0] reg_w_addr_o,
    output logic [DATA_W-1:0]     reg_w_data_o,
    output logic                  hold_o,
    output logic                  misalign_o
);

    state_t                r_state;
    state_t                w_next;

    // Latched request fields, stable from IDLE->REQ until the transaction ends
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [3:0]            r_be;
    logic [DATA_W-1:0]     r_wdata;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_rd_ena;

    // Write-back bundle
    logic                  r_wb_ena;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0]     r_wb_data;
    logic                  r_misalign;

    logic                  w_is_store;
    logic                  w_is_mem;
    logic [ADDR_W-1:0]     w_addr;
    logic [2:0]            w_funct3;
    logic [3:0]            w_be;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_misalign;
    logic [DATA_W-1:0]     w_ld_data;

    logic                  w_hold;
    logic                  w_accept;
    logic                  w_alu_wb;
    logic                  w_mis_wb;
    logic                  w_ld_done;

    wire                   w_unused_inst = ^{inst_i[31:15], inst_i[11:0]};

    // A store takes priority when both enables are raised
    assign w_is_store = mem_w_ena_i;
    assign w_is_mem   = mem_w_ena_i | mem_r_ena_i;
    assign w_addr     = w_is_store ? mem_w_addr_i : mem_r_addr_i;
    assign w_funct3   = inst_i[14:12];

    lsu_align u_lsu_align (
        .i_req_funct3  (w_funct3),
        .i_req_addr_lo (w_addr[1:0]),
        .i_req_wdata   (mem_w_data_i),
        .o_req_be      (w_be),
        .o_req_wdata   (w_wdata),
        .o_misalign    (w_misalign),
        .i_ld_funct3   (r_funct3),
        .i_ld_addr_lo  (r_addr_lo),
        .i_ld_rdata    (dmem_rdata_i),
        .o_ld_data     (w_ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control; hold drops in the cycle the bus completes
    always_comb begin
        w_next    = r_state;
        w_hold    = 1'b0;
        w_accept  = 1'b0;
        w_alu_wb  = 1'b0;
        w_mis_wb  = 1'b0;
        w_ld_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_is_mem) begin
                    w_alu_wb = 1'b1;
                end else if (w_misalign) begin
                    w_mis_wb = 1'b1;
                end else begin
                    w_accept = 1'b1;
                    w_hold   = 1'b1;
                    w_next   = ST_REQ;
                end
            end
            ST_REQ: begin
                w_hold = 1'b1;
                if (dmem_gnt_i) begin
                    if (r_we) begin
                        w_hold = 1'b0;
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_hold = 1'b1;
                if (dmem_rvalid_i) begin
                    w_hold    = 1'b0;
                    w_ld_done = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Capture the request fields when an aligned access leaves IDLE
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= 4'b0000;
            r_wdata   <= ZERO_WORD;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_rd      <= '0;
            r_rd_ena  <= 1'b0;
        end else if (w_accept) begin
            r_we      <= w_is_store;
            r_addr    <= {w_addr[ADDR_W-1:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_funct3  <= w_funct3;
            r_addr_lo <= w_addr[1:0];
            r_rd      <= reg_w_addr_i;
            r_rd_ena  <= reg_w_ena_i;
        end
    end

    // Write-back bundle: valid only in the cycle after an ALU op or a load return
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wb_ena   <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= ZERO_WORD;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_mis_wb;
            if (w_alu_wb) begin
                r_wb_ena  <= reg_w_ena_i & (|reg_w_addr_i);
                r_wb_addr <= reg_w_addr_i;
                r_wb_data <= reg_w_data_i;
            end else if (w_ld_done) begin
                r_wb_ena  <= r_rd_ena & (|r_rd);
                r_wb_addr <= r_rd;
                r_wb_data <= w_ld_data;
            end else begin
                r_wb_ena  <= 1'b0;
            end
        end
    end

    assign dmem_req_o   = (r_state == ST_REQ);
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;

    assign reg_w_ena_o  = r_wb_ena;
    assign reg_w_addr_o = r_wb_addr;
    assign reg_w_data_o = r_wb_data;
    assign hold_o       = w_hold;
    assign misalign_o   = r_misalign;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access with a reactive data-memory model
module tb_mem_access;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] inst_i;
    logic        mem_r_ena_i, mem_w_ena_i;
    logic [31:0] mem_r_addr_i, mem_w_addr_i, mem_w_data_i;
    logic        reg_w_ena_i;
    logic [4:0]  reg_w_addr_i;
    logic [31:0] reg_w_data_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        reg_w_ena_o;
    logic [4:0]  reg_w_addr_o;
    logic [31:0] reg_w_data_o;
    logic        hold_o, misalign_o;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .inst_i(inst_i),
        .mem_r_ena_i(mem_r_ena_i), .mem_r_addr_i(mem_r_addr_i),
        .mem_w_ena_i(mem_w_ena_i), .mem_w_addr_i(mem_w_addr_i), .mem_w_data_i(mem_w_data_i),
        .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i), .reg_w_data_i(reg_w_data_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o),
        .hold_o(hold_o), .misalign_o(misalign_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    req_t        req_q[$];
    wb_t         wb_q[$];
    int          mis_exp  = 0;
    int          mis_seen = 0;
    int          nchk     = 0;
    int          npass    = 0;

    // Reference memory: byte array at 0x100..0x13F; bus memory: words seen by the DUT
    logic [7:0]  ref_mem[0:63];
    logic [31:0] bus_mem[0:15];

    int          gnt_dly = 0;
    int          rd_dly  = 0;
    bit          rnd_dly = 1'b0;
    bit          req_active = 1'b0;
    int          gnt_wait = 0;
    bit          rd_pending = 1'b0;
    int          rd_cnt = 0;
    logic [31:0] rd_word = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    // Data-memory responder: grants after a chosen delay, returns read data later
    initial begin
        req_t e;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            if (dmem_rvalid_i) rd_pending = 1'b0;
            if (arst_n && dmem_req_o) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    e = req_q[0];
                    check("req_we", {31'h0, dmem_we_o}, {31'h0, e.we});
                    check("req_addr", dmem_addr_o, e.addr);
                    if (e.we) begin
                        check("req_be", {28'h0, dmem_be_o}, {28'h0, e.be});
                        check("req_wdata", dmem_wdata_o, e.wdata);
                    end
                    if (dmem_gnt_i) begin
                        void'(req_q.pop_front());
                        req_active = 1'b0;
                        if (dmem_we_o) begin
                            for (int i = 0; i < 4; i++)
                                if (dmem_be_o[i]) bus_mem[dmem_addr_o[5:2]][8*i +: 8] = dmem_wdata_o[8*i +: 8];
                        end else begin
                            rd_pending = 1'b1;
                            rd_cnt     = rnd_dly ? int'($urandom_range(0, 2)) : rd_dly;
                            rd_word    = bus_mem[dmem_addr_o[5:2]];
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = $urandom;
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = rd_word;
                end else begin
                    rd_cnt--;
                end
            end
            if (dmem_req_o) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    gnt_wait   = rnd_dly ? int'($urandom_range(0, 3)) : gnt_dly;
                end
                if (gnt_wait == 0) dmem_gnt_i = 1'b1;
                else gnt_wait--;
            end
        end
    end

    // Write-back monitor
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (reg_w_ena_o) begin
                    if (wb_q.size() == 0) begin
                        check("unexpected_wb", 32'd1, 32'd0);
                    end else begin
                        w = wb_q.pop_front();
                        check("wb_rd", {27'h0, reg_w_addr_o}, {27'h0, w.rd});
                        check("wb_data", reg_w_data_o, w.data);
                    end
                end
                if (misalign_o) mis_seen++;
            end
        end
    end

    task automatic drive_idle();
        inst_i       = 32'h0;
        mem_r_ena_i  = 1'b0;
        mem_w_ena_i  = 1'b0;
        mem_r_addr_i = 32'h0;
        mem_w_addr_i = 32'h0;
        mem_w_data_i = 32'h0;
        reg_w_ena_i  = 1'b0;
        reg_w_addr_i = 5'd0;
        reg_w_data_i = 32'h0;
    endtask

    // Computes the expected outcome, presents one instruction and waits until it leaves EX
    task automatic issue(input bit is_ld, input bit is_st, input logic [2:0] f3,
                         input logic [31:0] raddr, input logic [31:0] waddr,
                         input logic [31:0] wdata, input logic [4:0] rd, input bit ena,
                         input logic [31:0] alu, output int holds);
        logic [31:0] a, v, rep;
        int          s, off;
        bit          done;
        req_t        rq;
        wb_t         wq;
        if (is_ld || is_st) begin
            a   = is_st ? waddr : raddr;
            s   = acc_size(f3);
            off = int'(a - 32'h100);
            if ((a % s) != 0) begin
                mis_exp++;
            end else if (is_st) begin
                for (int i = 0; i < s; i++) ref_mem[off + i] = wdata[8*i +: 8];
                if (s == 1)      rep = {4{wdata[7:0]}};
                else if (s == 2) rep = {2{wdata[15:0]}};
                else             rep = wdata;
                rq.we = 1'b1; rq.addr = a & ~32'h3;
                rq.be = 4'(((1 << s) - 1) << (a % 4)); rq.wdata = rep;
                req_q.push_back(rq);
            end else begin
                v = 32'h0;
                for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[off + i];
                if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
                if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
                rq.we = 1'b0; rq.addr = a & ~32'h3; rq.be = 4'h0; rq.wdata = 32'h0;
                req_q.push_back(rq);
                if (ena && rd != 0) begin wq.rd = rd; wq.data = v; wb_q.push_back(wq); end
            end
        end else if (ena && rd != 0) begin
            wq.rd = rd; wq.data = alu; wb_q.push_back(wq);
        end
        inst_i        = $urandom;
        inst_i[14:12] = f3;
        mem_r_ena_i   = is_ld;
        mem_w_ena_i   = is_st;
        mem_r_addr_i  = raddr;
        mem_w_addr_i  = waddr;
        mem_w_data_i  = wdata;
        reg_w_ena_i   = ena;
        reg_w_addr_i  = rd;
        reg_w_data_i  = alu;
        holds = 0;
        done  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (hold_o) holds++;
            @(posedge clk);
            #2;
            if (holds == c) begin done = 1'b1; break; end
        end
        if (!done) check("issue_timeout", 32'd0, 32'd1);
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h;
        int mis0;
        req_t rq;
        for (int w = 0; w < 16; w++) begin
            bus_mem[w] = $urandom;
            for (int i = 0; i < 4; i++) ref_mem[4*w + i] = bus_mem[w][8*i +: 8];
        end
        bus_mem[0] = 32'h80FF_0000;
        for (int i = 0; i < 4; i++) ref_mem[i] = bus_mem[0][8*i +: 8];
        drive_idle();
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb", {reg_w_ena_o, reg_w_addr_o, 26'h0}, 32'h0);
        check("rst_wb_data", reg_w_data_o, 32'h0);
        check("rst_ctrl", {29'h0, dmem_req_o, hold_o, misalign_o}, 32'h0);
        check("rst_bus", {27'h0, dmem_we_o, dmem_be_o}, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #2;

        // Non-memory op: 1-cycle latency, no hold
        issue(0, 0, 3'd0, 0, 0, 0, 5'd5, 1, 32'h1234_5678, h);
        check("alu_hold", h, 0);
        check("alu_wb_data", reg_w_data_o, 32'h1234_5678);
        check("alu_wb", {26'h0, reg_w_ena_o, reg_w_addr_o}, {26'h0, 1'b1, 5'd5});

        // LB / LBU at 0x103, gnt first REQ cycle, rvalid next cycle
        issue(1, 0, 3'd0, 32'h103, 0, 0, 5'd7, 1, 32'h0, h);
        check("lb_hold_cycles", h, 2);
        check("lb_data", reg_w_data_o, 32'hFFFF_FF80);
        issue(1, 0, 3'd4, 32'h103, 0, 0, 5'd8, 1, 32'h0, h);
        check("lbu_hold_cycles", h, 2);
        check("lbu_data", reg_w_data_o, 32'h0000_0080);

        // SH at 0x102 with grant delayed 3 cycles
        gnt_dly = 3;
        issue(0, 1, 3'd1, 0, 32'h102, 32'hAAAA_BEEF, 5'd0, 0, 32'h0, h);
        check("sh_hold_cycles", h, 4);
        check("sh_mem", bus_mem[0], 32'hBEEF_0000);
        gnt_dly = 0;

        // LW at 0x101: misaligned, no request, single pulse
        mis0 = mis_exp;
        issue(1, 0, 3'd2, 32'h101, 0, 0, 5'd3, 1, 32'h0, h);
        check("mis_hold", h, 0);
        check("mis_pulse", {30'h0, misalign_o, reg_w_ena_o}, 32'h2);
        @(posedge clk);
        #2;
        check("mis_pulse_end", {31'h0, misalign_o}, 32'h0);
        check("mis_counted", mis_exp - mis0, 1);
        issue(0, 0, 3'd0, 0, 0, 0, 5'd4, 1, 32'hCAFE_0001, h);
        check("after_mis_wb", reg_w_data_o, 32'hCAFE_0001);

        // Load to x0: bus completes, no write-back
        issue(1, 0, 3'd2, 32'h104, 0, 0, 5'd0, 1, 32'h0, h);
        check("rd0_ena", {31'h0, reg_w_ena_o}, 32'h0);
        check("rd0_bus_done", req_q.size(), 0);

        // Reset while waiting for read data
        rd_dly = 4;
        rq.we = 1'b0; rq.addr = 32'h108; rq.be = 4'h0; rq.wdata = 32'h0;
        req_q.push_back(rq);
        inst_i = 32'h0000_2000; mem_r_ena_i = 1'b1; mem_r_addr_i = 32'h108;
        reg_w_ena_i = 1'b1; reg_w_addr_i = 5'd9;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("wait_state", {30'h0, hold_o, dmem_req_o}, 32'h2);
        drive_idle();
        #1 arst_n = 1'b0;
        #1;
        check("arst_outs", {26'h0, reg_w_ena_o, dmem_req_o, hold_o, misalign_o, dmem_we_o, 1'b0}, 32'h0);
        check("arst_data", reg_w_data_o | dmem_addr_o | dmem_wdata_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("post_rst_idle", {29'h0, hold_o, dmem_req_o, reg_w_ena_o}, 32'h0);
        end
        check("late_rvalid_seen", {31'h0, rd_pending}, 32'h0);
        rd_dly = 0;
        @(posedge clk);
        #2;
        issue(0, 0, 3'd0, 0, 0, 0, 5'd11, 1, 32'h0BAD_F00D, h);
        check("post_rst_alu", reg_w_data_o, 32'h0BAD_F00D);

        // Randomized traffic with random bus delays
        rnd_dly = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [2:0]  f3;
            logic [31:0] ra, wa;
            kind = int'($urandom_range(0, 3));
            f3   = 3'($urandom_range(0, 7));
            ra   = 32'h100 + $urandom_range(0, 63);
            wa   = 32'h100 + $urandom_range(0, 63);
            issue(kind == 1 || kind == 3, kind >= 2, f3, ra, wa, $urandom,
                  5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, $urandom, h);
            if (kind == 0) check("rand_alu_hold", h, 0);
        end

        repeat (5) @(posedge clk);
        #2;
        check("wb_q_drained", wb_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);
        check("misalign_count", mis_seen, mis_exp);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
